x1_vram_arbiter: RTL and testbench
==================================

# x1_vram_arbiter

Arbiter that shares the 2 KB text VRAM and 2 KB attribute VRAM between the Z80 I/O bus and the video character fetcher. It sits between the CPU/bus glue, which supplies Z80 strobes and data, and the two VRAM `dpram` instances, which have a 1-clock registered read. It also sequences each access and stretches CPU I/O cycles with `cpu_wait_n` while VRAM is busy.

## Interface
Parameters:
- `AW`, 11, VRAM address width per plane (2 KB).

Ports:
- `clk_sys` in 1: system clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `cpu_a` in 16: Z80 address bus.
- `cpu_iorq_n` in 1: Z80 IORQ, active-low.
- `cpu_rd_n` in 1: Z80 RD, active-low.
- `cpu_wr_n` in 1: Z80 WR, active-low.
- `cpu_dout` in 8: CPU write data.
- `cpu_din` out 8: read data returned to CPU.
- `cpu_wait_n` out 1: Z80 WAIT, active-low.
- `vid_req` in 1: one-cycle fetch request.
- `vid_a` in AW: character cell address, sampled with `vid_req`.
- `vid_ack` out 1: one-cycle fetch-complete pulse.
- `vid_text` out 8: fetched character code.
- `vid_attr` out 8: fetched attribute.
- `vid_overrun` out 1: sticky protocol-error flag.
- `tram_a`, `aram_a` out AW: text and attribute VRAM addresses.
- `tram_we`, `aram_we` out 1: VRAM write enables.
- `vram_d` out 8: VRAM write data, shared by both planes.
- `tram_q`, `aram_q` in 8: VRAM read data, valid 1 clock after the address is presented.

## Operation
- I/O decode, valid only while `cpu_iorq_n`=0:
  - `cpu_a[15:11]`=5'b00100 selects attribute; 0x2800–0x2FFF mirrors it.
  - `cpu_a[15:11]`=5'b00110 selects text; 0x3800–0x3FFF mirrors it.
  - Offset is `cpu_a[AW-1:0]`.
  - Any other I/O address: ignored, no wait.
- CPU request capture:
  - Set `cpu_pend` on the first cycle where the decode hits and (`cpu_rd_n`=0 or `cpu_wr_n`=0).
  - Latch address, plane, direction and `cpu_dout` at that moment.
  - Do not re-arm until `cpu_iorq_n` has returned high.
  - `cpu_wait_n`=0 from the capture cycle until the access is done.
- Video request capture: `vid_req`=1 sets `vid_pend` and latches `vid_a`.
  - If `vid_req` arrives while `vid_pend` is set or a video access is in flight, the request is dropped and `vid_overrun` is set.
  - `vid_overrun` clears only on reset.
- FSM states:
  - IDLE: grant when any request is pending.
    - If only one is pending, grant it.
    - If both are pending, grant the one not granted last (`last_vid` register; reset value = video-last, so the CPU wins the first tie).
    - Video grant → VRD. CPU read → CRD. CPU write → CWR.
  - VRD: drive `vid_a` on both `tram_a` and `aram_a`. Go to VCAP.
  - VCAP: register `tram_q` into `vid_text` and `aram_q` into `vid_attr`, pulse `vid_ack`, clear `vid_pend`. Go to IDLE.
  - CRD: drive the offset on the selected plane. Go to CCAP.
  - CCAP: register the selected q into `cpu_din`, release wait, clear `cpu_pend`. Go to IDLE.
  - CWR: drive offset and `vram_d`, assert the selected `*_we` for exactly 1 clock, release wait, clear `cpu_pend`. Go to IDLE.
- `cpu_din` holds its value until the next CPU read capture.

## Timing
- Reset values:
  - State IDLE; `cpu_wait_n`=1; `vid_ack`=0; `tram_we`=`aram_we`=0; `vid_overrun`=0.
  - `cpu_din`, `vid_text`, `vid_attr`, addresses and `vram_d` all 0.
  - `cpu_pend`, `vid_pend`, `last_vid` are cleared/reset as above.
  - A reset asserted mid-access abandons the access with no write issued; `cpu_wait_n` is 1 on the clock after reset is sampled.
- Video latency, arbiter idle: `vid_req` sampled at edge N → IDLE grants at N+1 → VRD at N+2 → VCAP drives `vid_ack` high during the cycle after N+3.
  - Worst case adds one CPU access (≤3 clocks).
- CPU latency, arbiter idle:
  - Read: `cpu_wait_n` low for 4 clocks.
  - Write: `cpu_wait_n` low for 3 clocks.
  - Worst case adds one video access (3 clocks).
- A request arriving in the same cycle as IDLE grants the other requester waits exactly one access.
- Write enable never coincides with a video read of the same plane; accesses are serialized.
- Outputs are registered. The only combinational input→output path is none.

## Structure
- Package `x1_pkg`:
  - FSM state enum {IDLE, VRD, VCAP, CRD, CCAP, CWR}.
  - Constants `X1_IO_ATTR`=5'b00100 and `X1_IO_TEXT`=5'b00110.
  - `X1_VRAM_AW`=11.
- Sub-module `x1_vram_io_decode`: combinational I/O decode producing hit, plane and offset.
- Target size: approximately 200 lines of RTL.

## Test plan
- Reset, then CPU OUT 0x3005←0x41 → `tram_we` pulses once with `tram_a`=0x005 and `vram_d`=0x41. Then IN 0x3005 → `cpu_din`=0x41, with `cpu_wait_n` low for 4 clocks.
- OUT 0x2805←0x07 (mirror) → `aram_we` with `aram_a`=0x005. Then `vid_req` with `vid_a`=0x005 → `vid_ack` 3 clocks later with `vid_text`=0x41 and `vid_attr`=0x07.
- `vid_req` and a CPU read captured in the same cycle after reset → CPU served first. `vid_ack` arrives 3 clocks later than the idle case. On a repeat tie, video is served first.
- `vid_req` reasserted while the previous fetch is pending → `vid_overrun`=1 and stays 1. The first fetch still acks exactly once.
- IN 0x1000 (no decode hit) → `cpu_wait_n` stays 1 and no write enables assert. A long `cpu_iorq_n` low cycle on 0x3000 produces exactly one access.
- Reset asserted while in CWR and in CCAP → no further `*_we`, `cpu_wait_n`=1 and `vid_ack`=0 on the next clock.

Source files
------------

// File: rtl/x1_pkg.sv
// Shared types and constants for the X1 VRAM arbiter slice.
package x1_pkg;

  localparam int unsigned X1_VRAM_AW = 11;

  // I/O page selects on cpu_a[15:11]; bit 11 is a don't-care mirror.
  localparam logic [4:0] X1_IO_ATTR = 5'b00100;
  localparam logic [4:0] X1_IO_TEXT = 5'b00110;

  typedef enum logic [2:0] {IDLE, VRD, VCAP, CRD, CCAP, CWR} x1_state_e;

endpackage

// File: rtl/x1_vram_io_decode.sv
// Combinational Z80 I/O decode for the text and attribute VRAM windows.
module x1_vram_io_decode
  import x1_pkg::*;
#(
  parameter int unsigned AW = X1_VRAM_AW
) (
  input  logic [15:0]   cpu_a,
  input  logic          cpu_iorq_n,
  output logic          hit,
  output logic          sel_text,
  output logic [AW-1:0] offset
);

  logic attr_hit;
  logic text_hit;
  logic unused_mirror;

  assign unused_mirror = cpu_a[11];

  always_comb begin
    attr_hit = (cpu_a[15:12] == X1_IO_ATTR[4:1]);
    text_hit = (cpu_a[15:12] == X1_IO_TEXT[4:1]);
    hit      = !cpu_iorq_n && (attr_hit || text_hit);
    sel_text = text_hit;
    offset   = cpu_a[AW-1:0];
  end

endmodule

// File: rtl/x1_vram_arbiter.sv
// Serialises CPU I/O and video character fetches onto the text/attribute VRAMs,
// stretching CPU cycles with WAIT while an access is outstanding.
module x1_vram_arbiter
  import x1_pkg::*;
#(
  parameter int unsigned AW = X1_VRAM_AW
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic [15:0]   cpu_a,
  input  logic          cpu_iorq_n,
  input  logic          cpu_rd_n,
  input  logic          cpu_wr_n,
  input  logic [7:0]    cpu_dout,
  output logic [7:0]    cpu_din,
  output logic          cpu_wait_n,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_a,
  output logic          vid_ack,
  output logic [7:0]    vid_text,
  output logic [7:0]    vid_attr,
  output logic          vid_overrun,
  output logic [AW-1:0] tram_a,
  output logic [AW-1:0] aram_a,
  output logic          tram_we,
  output logic          aram_we,
  output logic [7:0]    vram_d,
  input  logic [7:0]    tram_q,
  input  logic [7:0]    aram_q
);

  x1_state_e     state_q, state_d;
  logic          cpu_pend_q, cpu_pend_d, cpu_hold_q, cpu_hold_d;
  logic [AW-1:0] cpu_addr_q, cpu_addr_d, vid_addr_q, vid_addr_d;
  logic          cpu_text_q, cpu_text_d, cpu_write_q, cpu_write_d;
  logic [7:0]    cpu_data_q, cpu_data_d;
  logic          vid_pend_q, vid_pend_d, last_vid_q, last_vid_d;
  logic [7:0]    cpu_din_q, cpu_din_d, vid_text_q, vid_text_d, vid_attr_q, vid_attr_d;
  logic          wait_n_q, wait_n_d, vid_ack_q, vid_ack_d, overrun_q, overrun_d;
  logic [AW-1:0] tram_a_q, tram_a_d, aram_a_q, aram_a_d;
  logic          tram_we_q, tram_we_d, aram_we_q, aram_we_d;
  logic [7:0]    vram_d_q, vram_d_d;

  logic          dec_hit, dec_text, cpu_capture, vid_busy;
  logic [AW-1:0] dec_offset;

  x1_vram_io_decode #(.AW(AW)) u_decode (
    .cpu_a      (cpu_a),
    .cpu_iorq_n (cpu_iorq_n),
    .hit        (dec_hit),
    .sel_text   (dec_text),
    .offset     (dec_offset)
  );

  always_comb begin
    state_d     = state_q;
    cpu_pend_d  = cpu_pend_q;
    cpu_addr_d  = cpu_addr_q;
    cpu_text_d  = cpu_text_q;
    cpu_write_d = cpu_write_q;
    cpu_data_d  = cpu_data_q;
    vid_pend_d  = vid_pend_q;
    vid_addr_d  = vid_addr_q;
    last_vid_d  = last_vid_q;
    cpu_din_d   = cpu_din_q;
    vid_text_d  = vid_text_q;
    vid_attr_d  = vid_attr_q;
    wait_n_d    = wait_n_q;
    overrun_d   = overrun_q;
    tram_a_d    = tram_a_q;
    aram_a_d    = aram_a_q;
    vram_d_d    = vram_d_q;
    vid_ack_d   = 1'b0;
    tram_we_d   = 1'b0;
    aram_we_d   = 1'b0;

    // One capture per IORQ cycle; the hold flag re-arms only once IORQ goes high.
    cpu_capture = dec_hit && (!cpu_rd_n || !cpu_wr_n) && !cpu_hold_q && !cpu_pend_q;
    cpu_hold_d  = cpu_iorq_n ? 1'b0 : (cpu_hold_q || cpu_capture);
    if (cpu_capture) begin
      cpu_pend_d  = 1'b1;
      cpu_addr_d  = dec_offset;
      cpu_text_d  = dec_text;
      cpu_write_d = !cpu_wr_n;
      cpu_data_d  = cpu_dout;
      wait_n_d    = 1'b0;
    end

    vid_busy = vid_pend_q || (state_q == VRD) || (state_q == VCAP);
    if (vid_req) begin
      if (vid_busy) begin
        overrun_d = 1'b1;
      end else begin
        vid_pend_d = 1'b1;
        vid_addr_d = vid_a;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (vid_pend_q && (!cpu_pend_q || !last_vid_q)) begin
          state_d    = VRD;
          last_vid_d = 1'b1;
          tram_a_d   = vid_addr_q;
          aram_a_d   = vid_addr_q;
        end else if (cpu_pend_q) begin
          last_vid_d = 1'b0;
          state_d    = cpu_write_q ? CWR : CRD;
          vram_d_d   = cpu_write_q ? cpu_data_q : vram_d_q;
          if (cpu_text_q) tram_a_d = cpu_addr_q;
          else            aram_a_d = cpu_addr_q;
        end
      end
      VRD: state_d = VCAP;
      VCAP: begin
        vid_text_d = tram_q;
        vid_attr_d = aram_q;
        vid_ack_d  = 1'b1;
        vid_pend_d = 1'b0;
        state_d    = IDLE;
      end
      CRD: state_d = CCAP;
      CCAP: begin
        cpu_din_d  = cpu_text_q ? tram_q : aram_q;
        wait_n_d   = 1'b1;
        cpu_pend_d = 1'b0;
        state_d    = IDLE;
      end
      CWR: begin
        tram_we_d  = cpu_text_q;
        aram_we_d  = !cpu_text_q;
        wait_n_d   = 1'b1;
        cpu_pend_d = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= IDLE;
      cpu_pend_q  <= 1'b0;
      cpu_hold_q  <= 1'b0;
      cpu_addr_q  <= '0;
      cpu_text_q  <= 1'b0;
      cpu_write_q <= 1'b0;
      cpu_data_q  <= '0;
      vid_pend_q  <= 1'b0;
      vid_addr_q  <= '0;
      last_vid_q  <= 1'b1;
      cpu_din_q   <= '0;
      vid_text_q  <= '0;
      vid_attr_q  <= '0;
      wait_n_q    <= 1'b1;
      vid_ack_q   <= 1'b0;
      overrun_q   <= 1'b0;
      tram_a_q    <= '0;
      aram_a_q    <= '0;
      tram_we_q   <= 1'b0;
      aram_we_q   <= 1'b0;
      vram_d_q    <= '0;
    end else begin
      state_q     <= state_d;
      cpu_pend_q  <= cpu_pend_d;
      cpu_hold_q  <= cpu_hold_d;
      cpu_addr_q  <= cpu_addr_d;
      cpu_text_q  <= cpu_text_d;
      cpu_write_q <= cpu_write_d;
      cpu_data_q  <= cpu_data_d;
      vid_pend_q  <= vid_pend_d;
      vid_addr_q  <= vid_addr_d;
      last_vid_q  <= last_vid_d;
      cpu_din_q   <= cpu_din_d;
      vid_text_q  <= vid_text_d;
      vid_attr_q  <= vid_attr_d;
      wait_n_q    <= wait_n_d;
      vid_ack_q   <= vid_ack_d;
      overrun_q   <= overrun_d;
      tram_a_q    <= tram_a_d;
      aram_a_q    <= aram_a_d;
      tram_we_q   <= tram_we_d;
      aram_we_q   <= aram_we_d;
      vram_d_q    <= vram_d_d;
    end
  end

  assign cpu_din     = cpu_din_q;
  assign cpu_wait_n  = wait_n_q;
  assign vid_ack     = vid_ack_q;
  assign vid_text    = vid_text_q;
  assign vid_attr    = vid_attr_q;
  assign vid_overrun = overrun_q;
  assign tram_a      = tram_a_q;
  assign aram_a      = aram_a_q;
  assign tram_we     = tram_we_q;
  assign aram_we     = aram_we_q;
  assign vram_d      = vram_d_q;

endmodule

// File: tb/tb_x1_vram_arbiter.sv
// Bench for x1_vram_arbiter: directed test-plan steps followed by randomized traffic
// checked against a transaction-level model of VRAM contents and arbitration order.
module tb_x1_vram_arbiter;

  localparam int AW = 11;

  logic          clk_sys = 1'b0;
  logic          reset = 1'b1;
  logic [15:0]   cpu_a = '0;
  logic          cpu_iorq_n = 1'b1, cpu_rd_n = 1'b1, cpu_wr_n = 1'b1;
  logic [7:0]    cpu_dout = '0, cpu_din;
  logic          cpu_wait_n;
  logic          vid_req = 1'b0;
  logic [AW-1:0] vid_a = '0;
  logic          vid_ack, vid_overrun;
  logic [7:0]    vid_text, vid_attr;
  logic [AW-1:0] tram_a, aram_a;
  logic          tram_we, aram_we;
  logic [7:0]    vram_d, tram_q, aram_q;
  logic          mem_clr = 1'b1;

  int n_cmp = 0, n_fail = 0;
  int n_twe = 0, n_awe = 0, n_ack = 0;
  logic [AW-1:0] twe_a = '0, awe_a = '0;
  logic [7:0]    twe_d = '0, awe_d = '0;

  // Reference model: VRAM contents and who was served last on a tie.
  logic [7:0] ref_t [2048];
  logic [7:0] ref_a [2048];
  bit         ref_last_vid;

  logic [7:0] tmem [2048];
  logic [7:0] amem [2048];

  always #5 clk_sys = ~clk_sys;

  x1_vram_arbiter #(.AW(AW)) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .cpu_a       (cpu_a),
    .cpu_iorq_n  (cpu_iorq_n),
    .cpu_rd_n    (cpu_rd_n),
    .cpu_wr_n    (cpu_wr_n),
    .cpu_dout    (cpu_dout),
    .cpu_din     (cpu_din),
    .cpu_wait_n  (cpu_wait_n),
    .vid_req     (vid_req),
    .vid_a       (vid_a),
    .vid_ack     (vid_ack),
    .vid_text    (vid_text),
    .vid_attr    (vid_attr),
    .vid_overrun (vid_overrun),
    .tram_a      (tram_a),
    .aram_a      (aram_a),
    .tram_we     (tram_we),
    .aram_we     (aram_we),
    .vram_d      (vram_d),
    .tram_q      (tram_q),
    .aram_q      (aram_q)
  );

  // dpram stand-ins with a 1-clock registered read
  always @(posedge clk_sys) begin
    if (mem_clr) begin
      for (int i = 0; i < 2048; i++) tmem[i] <= '0;
    end else if (tram_we) begin
      tmem[tram_a] <= vram_d;
    end
    tram_q <= tmem[tram_a];
  end

  always @(posedge clk_sys) begin
    if (mem_clr) begin
      for (int i = 0; i < 2048; i++) amem[i] <= '0;
    end else if (aram_we) begin
      amem[aram_a] <= vram_d;
    end
    aram_q <= amem[aram_a];
  end

  // Event recorder: sees the values held during the cycle that ends at this edge.
  always @(posedge clk_sys) begin
    if (tram_we) begin n_twe <= n_twe + 1; twe_a <= tram_a; twe_d <= vram_d; end
    if (aram_we) begin n_awe <= n_awe + 1; awe_a <= aram_a; awe_d <= vram_d; end
    if (vid_ack) n_ack <= n_ack + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  function automatic logic [7:0] ref_rd(input logic [15:0] a);
    return (a[15:12] == 4'h3) ? ref_t[a[10:0]] : ref_a[a[10:0]];
  endfunction

  task automatic ref_wr(input logic [15:0] a, input logic [7:0] d);
    if (a[15:12] == 4'h3) ref_t[a[10:0]] = d;
    else                  ref_a[a[10:0]] = d;
  endtask

  // One Z80 I/O cycle; low = clocks WAIT was seen low after the capture clock.
  task automatic cpu_io(input bit wr, input logic [15:0] a, input logic [7:0] d, output int low);
    bit done = 1'b0;
    cpu_a = a; cpu_dout = d; cpu_iorq_n = 1'b0; cpu_rd_n = wr; cpu_wr_n = !wr;
    low = 0;
    for (int k = 0; k < 24 && !done; k++) begin
      @(negedge clk_sys);
      if (cpu_wait_n === 1'b0) low++;
      else done = 1'b1;
    end
    chk("cpu_wait_bound", {31'b0, done}, 32'd1);
    cpu_iorq_n = 1'b1; cpu_rd_n = 1'b1; cpu_wr_n = 1'b1;
  endtask

  // lat = edges from the request-sampling edge to the edge that raises vid_ack.
  task automatic vid_fetch(input logic [AW-1:0] a, output int lat, output logic [7:0] t,
                           output logic [7:0] at);
    bit done = 1'b0;
    vid_req = 1'b1; vid_a = a; lat = -1; t = '0; at = '0;
    for (int k = 1; k <= 24 && !done; k++) begin
      @(negedge clk_sys);
      vid_req = 1'b0;
      if (vid_ack === 1'b1) begin lat = k - 1; t = vid_text; at = vid_attr; done = 1'b1; end
    end
    chk("vid_ack_bound", {31'b0, done}, 32'd1);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    ref_last_vid = 1'b1;
    cyc(1);
  endtask

  // The capture clock counts as the first WAIT clock: reads stall 4, writes 3.
  task automatic do_write(input logic [15:0] a, input logic [7:0] d);
    int low, t0, a0;
    t0 = n_twe; a0 = n_awe;
    cpu_io(1'b1, a, d, low);
    cyc(1);
    chk("wr_stall", low + 1, 32'd3);
    if (a[15:12] == 4'h3) begin
      chk("wr_twe_cnt", n_twe - t0, 32'd1);
      chk("wr_awe_cnt", n_awe - a0, 32'd0);
      chk("wr_tram_a", {21'b0, twe_a}, {21'b0, a[10:0]});
      chk("wr_vram_d", {24'b0, twe_d}, {24'b0, d});
    end else begin
      chk("wr_awe_cnt", n_awe - a0, 32'd1);
      chk("wr_twe_cnt", n_twe - t0, 32'd0);
      chk("wr_aram_a", {21'b0, awe_a}, {21'b0, a[10:0]});
      chk("wr_vram_d", {24'b0, awe_d}, {24'b0, d});
    end
    ref_wr(a, d);
    ref_last_vid = 1'b0;
  endtask

  task automatic do_read(input logic [15:0] a);
    int low;
    cpu_io(1'b0, a, 8'h00, low);
    chk("rd_stall", low + 1, 32'd4);
    chk("rd_din", {24'b0, cpu_din}, {24'b0, ref_rd(a)});
    ref_last_vid = 1'b0;
    cyc(1);
  endtask

  task automatic do_vid(input logic [AW-1:0] a);
    int lat;
    logic [7:0] t, at;
    vid_fetch(a, lat, t, at);
    chk("vid_lat", lat, 32'd3);
    chk("vid_text", {24'b0, t}, {24'b0, ref_t[a]});
    chk("vid_attr", {24'b0, at}, {24'b0, ref_a[a]});
    ref_last_vid = 1'b1;
    cyc(1);
  endtask

  // CPU access and video fetch captured on the same edge: a tie for the arbiter.
  task automatic conc(input bit wr, input logic [15:0] a, input logic [7:0] d,
                      input logic [AW-1:0] va);
    int low, lat, exp_stall, exp_lat;
    logic [7:0] t, at, et, ea;
    fork
      cpu_io(wr, a, d, low);
      vid_fetch(va, lat, t, at);
    join
    if (ref_last_vid) begin
      exp_stall = wr ? 3 : 4;
      exp_lat   = wr ? 5 : 6;
      if (!wr) chk("tie_din", {24'b0, cpu_din}, {24'b0, ref_rd(a)});
      if (wr) ref_wr(a, d);
      et = ref_t[va]; ea = ref_a[va];
      ref_last_vid = 1'b1;
    end else begin
      exp_lat   = 3;
      exp_stall = wr ? 6 : 7;
      et = ref_t[va]; ea = ref_a[va];
      if (!wr) chk("tie_din", {24'b0, cpu_din}, {24'b0, ref_rd(a)});
      if (wr) ref_wr(a, d);
      ref_last_vid = 1'b0;
    end
    chk("tie_stall", low + 1, exp_stall);
    chk("tie_vid_lat", lat, exp_lat);
    chk("tie_vid_text", {24'b0, t}, {24'b0, et});
    chk("tie_vid_attr", {24'b0, at}, {24'b0, ea});
    cyc(2);
  endtask

  initial begin
    int low, base_t, base_a, base_k;
    logic [15:0] ra;
    logic [10:0] roff, voff;
    logic [7:0]  rd;
    bit          rtxt, rmir;
    int          op;

    for (int i = 0; i < 2048; i++) begin ref_t[i] = '0; ref_a[i] = '0; end
    ref_last_vid = 1'b1;

    // Reset values
    cyc(3);
    chk("rst_wait_n", {31'b0, cpu_wait_n}, 32'd1);
    chk("rst_vid_ack", {31'b0, vid_ack}, 32'd0);
    chk("rst_we", {30'b0, tram_we, aram_we}, 32'd0);
    chk("rst_overrun", {31'b0, vid_overrun}, 32'd0);
    chk("rst_cpu_din", {24'b0, cpu_din}, 32'd0);
    chk("rst_vid_data", {16'b0, vid_text, vid_attr}, 32'd0);
    chk("rst_addr", {10'b0, tram_a, aram_a}, 32'd0);
    chk("rst_vram_d", {24'b0, vram_d}, 32'd0);
    reset = 1'b0; mem_clr = 1'b0;
    cyc(2);

    // Basic write/read, mirror write, video fetch
    do_write(16'h3005, 8'h41);
    do_read(16'h3005);
    do_write(16'h2805, 8'h07);
    do_vid(11'h005);

    // Tie after reset: CPU first; after a CPU-only access the next tie goes to video
    apply_reset();
    conc(1'b0, 16'h3005, 8'h00, 11'h005);
    do_read(16'h2005);
    conc(1'b0, 16'h2005, 8'h00, 11'h005);

    // Overrun: second request while the first is pending
    base_k = n_ack;
    vid_req = 1'b1; vid_a = 11'h005;
    cyc(1);
    vid_req = 1'b1; vid_a = 11'h006;
    cyc(1);
    vid_req = 1'b0;
    cyc(8);
    chk("ovr_flag", {31'b0, vid_overrun}, 32'd1);
    chk("ovr_ack_once", n_ack - base_k, 32'd1);
    chk("ovr_vid_text", {24'b0, vid_text}, {24'b0, ref_t[11'h005]});
    ref_last_vid = 1'b1;
    do_vid(11'h005);
    chk("ovr_sticky", {31'b0, vid_overrun}, 32'd1);

    // Unmapped I/O: no wait, no writes
    base_t = n_twe; base_a = n_awe;
    cpu_io(1'b0, 16'h1000, 8'h00, low);
    chk("nohit_rd_wait", low, 32'd0);
    cyc(1);
    cpu_io(1'b1, 16'h1005, 8'h99, low);
    chk("nohit_wr_wait", low, 32'd0);
    cyc(2);
    chk("nohit_we", (n_twe - base_t) + (n_awe - base_a), 32'd0);

    // Long IORQ low: one access only
    cpu_a = 16'h3000; cpu_iorq_n = 1'b0; cpu_rd_n = 1'b0;
    low = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk_sys);
      if (cpu_wait_n === 1'b0) low++;
    end
    cpu_iorq_n = 1'b1; cpu_rd_n = 1'b1;
    chk("long_rd_wait", low, 32'd3);
    chk("long_rd_din", {24'b0, cpu_din}, {24'b0, ref_t[0]});
    cyc(1);
    base_t = n_twe;
    cpu_a = 16'h3000; cpu_dout = 8'h5a; cpu_iorq_n = 1'b0; cpu_wr_n = 1'b0;
    cyc(12);
    cpu_iorq_n = 1'b1; cpu_wr_n = 1'b1;
    cyc(1);
    chk("long_wr_once", n_twe - base_t, 32'd1);
    ref_t[0] = 8'h5a;
    ref_last_vid = 1'b0;

    // Reset while in CWR: the write is abandoned
    base_t = n_twe;
    cpu_a = 16'h3010; cpu_dout = 8'haa; cpu_iorq_n = 1'b0; cpu_wr_n = 1'b0;
    cyc(2);
    chk("cwr_wait_low", {31'b0, cpu_wait_n}, 32'd0);
    reset = 1'b1; cpu_iorq_n = 1'b1; cpu_wr_n = 1'b1;
    cyc(1);
    chk("cwr_rst_we", {30'b0, tram_we, aram_we}, 32'd0);
    chk("cwr_rst_wait_n", {31'b0, cpu_wait_n}, 32'd1);
    chk("cwr_rst_ack", {31'b0, vid_ack}, 32'd0);
    chk("cwr_rst_overrun", {31'b0, vid_overrun}, 32'd0);
    reset = 1'b0;
    cyc(3);
    chk("cwr_rst_no_write", n_twe - base_t, 32'd0);
    ref_last_vid = 1'b1;

    // Reset while in CCAP
    cpu_a = 16'h3005; cpu_iorq_n = 1'b0; cpu_rd_n = 1'b0;
    cyc(3);
    reset = 1'b1; cpu_iorq_n = 1'b1; cpu_rd_n = 1'b1;
    cyc(1);
    chk("ccap_rst_wait_n", {31'b0, cpu_wait_n}, 32'd1);
    chk("ccap_rst_we", {30'b0, tram_we, aram_we}, 32'd0);
    chk("ccap_rst_ack", {31'b0, vid_ack}, 32'd0);
    chk("ccap_rst_din", {24'b0, cpu_din}, 32'd0);
    reset = 1'b0;
    cyc(2);
    do_read(16'h3010);

    // Randomized traffic over a small address window
    for (int i = 0; i < 40; i++) begin
      op   = int'($urandom_range(0, 4));
      roff = 11'($urandom_range(0, 15));
      voff = 11'($urandom_range(0, 15));
      rtxt = 1'($urandom_range(0, 1));
      rmir = 1'($urandom_range(0, 1));
      rd   = 8'($urandom_range(0, 255));
      ra   = {(rtxt ? 4'h3 : 4'h2), rmir, roff};
      case (op)
        0: do_write(ra, rd);
        1: do_read(ra);
        2: do_vid(voff);
        3: conc(1'b0, ra, rd, voff);
        default: conc(1'b1, ra, rd, roff);
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
